// File: rtl/ccg_sched_pkg.sv
// Shared types and constants for the CCG evaluation scheduler.
// The optional truth-table sweep is enabled by defining CCG_SWEEP_EN.
package ccg_sched_pkg;

    localparam int CCG_IN_W  = 4;
    localparam int CCG_OUT_W = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } sched_state_e;

    // Sweep responses carry an id one past the last real requester.
    function automatic int sweep_id(input int nreq);
        return nreq;
    endfunction

endpackage

// File: rtl/ccg_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or
// after ptr (mod NREQ), returning a one-hot grant and its index.
module ccg_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [PTR_W-1:0] idx
);

    int               pos;
    logic [PTR_W-1:0] pos_idx;

    // Scan from the farthest offset back to ptr so the closest winner overwrites.
    always_comb begin
        gnt     = '0;
        idx     = '0;
        pos     = 0;
        pos_idx = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            pos     = (int'(ptr) + off) % NREQ;
            pos_idx = PTR_W'(pos);
            if (req[pos_idx]) begin
                gnt = NREQ'(1) << pos_idx;
                idx = pos_idx;
            end
        end
    end

endmodule

// File: rtl/ccg_eval_sched.sv
// Shares one combinational CCG circuit between NREQ requesters: arbitrate,
// drive, settle, capture, respond. Define CCG_SWEEP_EN for the truth-table sweep.
module ccg_eval_sched
    import ccg_sched_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int IN_W   = CCG_IN_W,
    parameter int OUT_W  = CCG_OUT_W,
    parameter int SETTLE = 1,
    parameter int ID_W   = $clog2(NREQ + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*IN_W-1:0] req_x,
    output logic [NREQ-1:0]      req_ready,
    output logic [IN_W-1:0]      eval_x,
    input  logic [OUT_W-1:0]     eval_f,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [IN_W-1:0]      rsp_x,
    output logic [OUT_W-1:0]     rsp_f,
    output logic                 rsp_last,
    input  logic                 sweep_start,
    output logic                 sweep_busy
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_DRIVE = DRIVE;
    localparam logic [1:0] S_RESP  = RESP;

    logic [1:0]       state;
    logic [PTR_W-1:0] rr_ptr;
    logic [CNT_W-1:0] settle_cnt;
    logic [ID_W-1:0]  cur_id;
    logic [NREQ-1:0]  arb_gnt;
    logic [PTR_W-1:0] arb_idx;
    logic             sweep_take;
    logic             accept;

    ccg_rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

`ifdef CCG_SWEEP_EN
    assign sweep_take = (state == S_IDLE) && sweep_start;
`else
    logic unused_sweep_start;
    assign unused_sweep_start = sweep_start;
    assign sweep_take         = 1'b0;
`endif

    assign accept = (state == S_IDLE) && !sweep_take && (|req_valid);

    // Gated by rst_n so every output reads 0 while reset is held.
    assign req_ready = (rst_n && state == S_IDLE && !sweep_take) ? arb_gnt : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            settle_cnt <= '0;
            cur_id     <= '0;
            eval_x     <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_x      <= '0;
            rsp_f      <= '0;
            rsp_last   <= 1'b0;
            sweep_busy <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (sweep_take) begin
                        state      <= S_DRIVE;
                        eval_x     <= '0;
                        cur_id     <= ID_W'(sweep_id(NREQ));
                        settle_cnt <= CNT_W'(SETTLE - 1);
                        sweep_busy <= 1'b1;
                    end else if (accept) begin
                        state      <= S_DRIVE;
                        eval_x     <= req_x[arb_idx*IN_W +: IN_W];
                        cur_id     <= ID_W'(arb_idx);
                        settle_cnt <= CNT_W'(SETTLE - 1);
                        rr_ptr     <= (int'(arb_idx) == NREQ - 1) ? '0 : arb_idx + 1'b1;
                    end
                end
                S_DRIVE: begin
                    // Capture on the last settle cycle; eval_x still holds the vector.
                    if (settle_cnt == '0) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_f     <= eval_f;
                        rsp_x     <= eval_x;
                        rsp_id    <= cur_id;
                        rsp_last  <= sweep_busy && (&eval_x);
                        eval_x    <= '0;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_last  <= 1'b0;
                        if (sweep_busy && !rsp_last) begin
                            state      <= S_DRIVE;
                            eval_x     <= rsp_x + 1'b1;
                            settle_cnt <= CNT_W'(SETTLE - 1);
                        end else begin
                            state      <= S_IDLE;
                            sweep_busy <= 1'b0;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ccg_eval_sched.sv
// Directed, table-driven bench for ccg_eval_sched (SETTLE=1 and SETTLE=3
// instances); the sweep sequence is exercised when CCG_SWEEP_EN is defined.
`timescale 1ns/1ps
module tb_ccg_eval_sched;

    localparam int NREQ  = 4;
    localparam int IN_W  = 4;
    localparam int OUT_W = 9;
    localparam int ID_W  = 3;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*IN_W-1:0] req_x;
    logic [NREQ-1:0]      req_ready;
    logic [IN_W-1:0]      eval_x;
    logic [OUT_W-1:0]     eval_f;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [IN_W-1:0]      rsp_x;
    logic [OUT_W-1:0]     rsp_f;
    logic                 rsp_last;
    logic                 sweep_start;
    logic                 sweep_busy;

    logic [NREQ-1:0]      req_valid_s3;
    logic [NREQ*IN_W-1:0] req_x_s3;
    logic [NREQ-1:0]      req_ready_s3;
    logic [IN_W-1:0]      eval_x_s3;
    logic [OUT_W-1:0]     eval_f_s3;
    logic                 rsp_valid_s3;
    logic [ID_W-1:0]      rsp_id_s3;
    logic [IN_W-1:0]      rsp_x_s3;
    logic [OUT_W-1:0]     rsp_f_s3;
    logic                 rsp_last_s3;
    logic                 sweep_busy_s3;
    logic [OUT_W-1:0]     dly1, dly2;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int           idx;
        logic [3:0]   x;
        logic [3:0]   exp_rdy;
        logic [8:0]   exp_f;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    // Stand-in for the CCG circuit, outputs f9..f1 packed as [8:0].
    function automatic logic [8:0] ccg_model(input logic [3:0] x);
        logic [8:0] f;
        f[8] = ~x[0] & ~x[3];
        f[7] = x[0] ^ x[1];
        f[6] = x[1] & x[2];
        f[5] = x[2] | x[3];
        f[4] = ^x;
        f[3] = x[0] & x[3];
        f[2] = ~(x[1] | x[2]);
        f[1] = x[3];
        f[0] = &x;
        return f;
    endfunction

    assign eval_f = ccg_model(eval_x);

    // Slow circuit for the SETTLE=3 instance: outputs lag the inputs by 2 cycles.
    always @(posedge clk) begin
        dly1 <= ccg_model(eval_x_s3);
        dly2 <= dly1;
    end
    assign eval_f_s3 = dly2;

    ccg_eval_sched #(.NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_x(req_x),
        .req_ready(req_ready), .eval_x(eval_x), .eval_f(eval_f),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_x(rsp_x), .rsp_f(rsp_f), .rsp_last(rsp_last),
        .sweep_start(sweep_start), .sweep_busy(sweep_busy)
    );

    ccg_eval_sched #(.NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(3)) dut_s3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_s3), .req_x(req_x_s3),
        .req_ready(req_ready_s3), .eval_x(eval_x_s3), .eval_f(eval_f_s3),
        .rsp_valid(rsp_valid_s3), .rsp_ready(1'b1), .rsp_id(rsp_id_s3),
        .rsp_x(rsp_x_s3), .rsp_f(rsp_f_s3), .rsp_last(rsp_last_s3),
        .sweep_start(1'b0), .sweep_busy(sweep_busy_s3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [3:0] x);
        req_x                    = '0;
        req_x[idx*IN_W +: IN_W]  = x;
        req_valid                = '0;
        req_valid[idx]           = 1'b1;
        #1;
    endtask

    task automatic waitRsp();
        for (int c = 0; c < 12 && !rsp_valid; c++) tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not complete");
    end

    initial begin
        vecs[0] = '{2, 4'h5, 4'b0100, 9'h0A0};
        vecs[1] = '{0, 4'h0, 4'b0001, 9'h104};
        vecs[2] = '{3, 4'hF, 4'b1000, 9'h06B};
        vecs[3] = '{1, 4'hA, 4'b0010, 9'h0A2};
        vecs[4] = '{2, 4'h9, 4'b0100, 9'h0AE};
        vecs[5] = '{0, 4'h6, 4'b0001, 9'h1E0};

        req_valid    = '0;
        req_x        = '0;
        rsp_ready    = 1'b1;
        sweep_start  = 1'b0;
        req_valid_s3 = '0;
        req_x_s3     = '0;

        #2;
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_eval_x", eval_x, 0);
        checkOutput("reset_rsp_f", rsp_f, 0);
        checkOutput("reset_sweep_busy", sweep_busy, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        // Single requests: grant at T, eval_x at T+1, response at T+2.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].idx, vecs[i].x);
            checkOutput("vec_req_ready", req_ready, vecs[i].exp_rdy);
            tick();
            req_valid = '0;
            #1;
            checkOutput("vec_eval_x", eval_x, vecs[i].x);
            checkOutput("vec_rsp_early", rsp_valid, 0);
            tick();
            checkOutput("vec_rsp_valid", rsp_valid, 1);
            checkOutput("vec_rsp_id", rsp_id, vecs[i].idx);
            checkOutput("vec_rsp_x", rsp_x, vecs[i].x);
            checkOutput("vec_rsp_f", rsp_f, vecs[i].exp_f);
            checkOutput("vec_rsp_last", rsp_last, 0);
            tick();
            checkOutput("vec_rsp_done", rsp_valid, 0);
        end

        // Round robin from a fresh pointer.
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        for (int i = 0; i < NREQ; i++) req_x[i*IN_W +: IN_W] = 4'(i + 3);
        req_valid = 4'hF;
        #1;
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 12 && req_ready == '0; c++) tick();
            checkOutput("rr_grant", req_ready, 32'(1) << (k % NREQ));
            tick();
            waitRsp();
            checkOutput("rr_rsp_id", rsp_id, k % NREQ);
            checkOutput("rr_rsp_x", rsp_x, (k % NREQ) + 3);
            tick();
        end
        req_valid = '0;

        // Backpressure: requester 1 served, requester 0 waits for IDLE.
        applyStimulus(1, 4'h3);
        checkOutput("bp_grant", req_ready, 4'b0010);
        tick();
        req_x[0 +: IN_W] = 4'hE;
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        #1;
        checkOutput("bp_drive_ready", req_ready, 0);
        tick();
        for (int c = 0; c < 5; c++) begin
            checkOutput("bp_hold_valid", rsp_valid, 1);
            checkOutput("bp_hold_x", rsp_x, 4'h3);
            checkOutput("bp_hold_id", rsp_id, 1);
            checkOutput("bp_hold_f", rsp_f, ccg_model(4'h3));
            checkOutput("bp_hold_ready", req_ready, 0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        checkOutput("bp_release", rsp_valid, 0);
        checkOutput("bp_next_grant", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        waitRsp();
        checkOutput("bp_next_id", rsp_id, 0);
        checkOutput("bp_next_x", rsp_x, 4'hE);
        tick();
        checkOutput("bp_idle", rsp_valid, 0);

        // Settle: SETTLE=3 instance with a 2-cycle-late circuit.
        req_x_s3[0 +: IN_W] = 4'hC;
        req_valid_s3 = 4'b0001;
        #1;
        checkOutput("s3_grant", req_ready_s3, 4'b0001);
        tick();
        req_valid_s3 = '0;
        for (int c = 0; c < 3; c++) begin
            checkOutput("s3_eval_x", eval_x_s3, 4'hC);
            checkOutput("s3_rsp_early", rsp_valid_s3, 0);
            tick();
        end
        checkOutput("s3_rsp_valid", rsp_valid_s3, 1);
        checkOutput("s3_rsp_f", rsp_f_s3, ccg_model(4'hC));
        checkOutput("s3_rsp_x", rsp_x_s3, 4'hC);
        checkOutput("s3_eval_clear", eval_x_s3, 0);
        tick();

`ifdef CCG_SWEEP_EN
        // Sweep wins over requester 1, which is served right after.
        req_x[1*IN_W +: IN_W] = 4'h5;
        req_valid   = 4'b0010;
        sweep_start = 1'b1;
        #1;
        checkOutput("sw_start_ready", req_ready, 0);
        tick();
        sweep_start = 1'b0;
        checkOutput("sw_busy", sweep_busy, 1);
        for (int v = 0; v < 16; v++) begin
            waitRsp();
            checkOutput("sw_rsp_x", rsp_x, v);
            checkOutput("sw_rsp_id", rsp_id, NREQ);
            checkOutput("sw_rsp_last", rsp_last, (v == 15) ? 1 : 0);
            checkOutput("sw_rsp_f", rsp_f, ccg_model(4'(v)));
            checkOutput("sw_req_blocked", req_ready, 0);
            tick();
        end
        checkOutput("sw_busy_done", sweep_busy, 0);
        checkOutput("sw_after_grant", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        waitRsp();
        checkOutput("sw_after_id", rsp_id, 1);
        checkOutput("sw_after_x", rsp_x, 4'h5);
        tick();
`else
        sweep_start = 1'b1;
        #1;
        tick();
        sweep_start = 1'b0;
        checkOutput("nosw_busy", sweep_busy, 0);
        tick();
        checkOutput("nosw_rsp_valid", rsp_valid, 0);
        checkOutput("nosw_rsp_last", rsp_last, 0);
`endif

        // Async reset mid-DRIVE; afterwards requester 0 wins and nothing stale appears.
        applyStimulus(2, 4'h7);
        checkOutput("ar_grant", req_ready, 4'b0100);
        tick();
        req_x[0 +: IN_W] = 4'hB;
        req_valid = 4'hF;
        checkOutput("ar_eval_x", eval_x, 4'h7);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("ar_eval_x0", eval_x, 0);
        checkOutput("ar_rsp_valid0", rsp_valid, 0);
        checkOutput("ar_req_ready0", req_ready, 0);
        checkOutput("ar_rsp_id0", rsp_id, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        checkOutput("ar_first_grant", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        #1;
        checkOutput("ar_no_stale", rsp_valid, 0);
        tick();
        checkOutput("ar_rsp_valid", rsp_valid, 1);
        checkOutput("ar_rsp_id", rsp_id, 0);
        checkOutput("ar_rsp_x", rsp_x, 4'hB);
        checkOutput("ar_rsp_f", rsp_f, ccg_model(4'hB));
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ccg_eval_sched.md
# ccg_eval_sched

Controller that shares one combinational CCG benchmark instance (4 inputs `x0..x3`, 9 outputs `f1..f9`) between several requesters. It grants one request at a time round-robin, drives the vector into the circuit, and waits a programmable settle time. It then captures the outputs and returns them with a valid/ready handshake. It sits between the bench/stimulus agents and the circuit under evaluation, and optionally runs an exhaustive truth-table sweep of the circuit.

## Interface
- `NREQ`, 4, number of external requesters (≥1)
- `IN_W`, 4, circuit input width
- `OUT_W`, 9, circuit output width
- `SETTLE`, 1, cycles the vector is held before capture (≥1)
- `ID_W`, `$clog2(NREQ+1)`, response id width (derived)

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NREQ: per-requester request valid.
- `req_x` in NREQ*IN_W: per-requester input vector; requester i uses bits [i*IN_W +: IN_W].
- `req_ready` out NREQ: one-hot grant/accept.
- `eval_x` out IN_W: drive to circuit `x3..x0`.
- `eval_f` in OUT_W: circuit outputs `f9..f1`.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response accepted.
- `rsp_id` out ID_W: requester index; value NREQ marks a sweep response.
- `rsp_x` out IN_W: vector echo.
- `rsp_f` out OUT_W: captured outputs.
- `rsp_last` out 1: final sweep response.
- `sweep_start` in 1: pulse that starts a sweep.
- `sweep_busy` out 1: sweep in progress.

## Operation
- FSM states are IDLE, DRIVE and RESP.
- IDLE:
  - `eval_x` = 0.
  - If any `req_valid` is set, grant the first valid requester at or after `rr_ptr` (mod NREQ). The matching `req_ready` bit is asserted combinationally this cycle.
  - Latch `req_x[i]` and id i, set `rr_ptr` = i+1 mod NREQ, and go to DRIVE.
- DRIVE:
  - `eval_x` = latched vector; the settle counter runs SETTLE-1 down to 0.
  - In the cycle the counter reaches 0, sample `eval_f` into `rsp_f` and go to RESP.
- RESP:
  - `rsp_valid` = 1, with `rsp_id`/`rsp_x`/`rsp_f` stable until `rsp_valid & rsp_ready`.
  - After the handshake, go to IDLE, or to DRIVE with the next vector during a sweep.
- `req_ready` is 0 outside IDLE. Deasserting `req_valid` without a grant is legal; nothing is latched.
- Reset value of every output is 0; `rr_ptr` = 0, state IDLE, sweep counter 0.
- Reset mid-operation aborts immediately. No response is emitted for the in-flight vector.

## Timing
- Request accepted in cycle T → `eval_x` valid T+1..T+SETTLE → `rsp_valid` rises T+SETTLE+1.
- Back-to-back throughput is one vector per SETTLE+2 cycles with `rsp_ready` tied high; IDLE costs one bubble.
- `rsp_f` is registered. `eval_f` is sampled only on the last DRIVE cycle.
- All outputs except `req_ready` are registered.

## Configuration
- Macro `CCG_SWEEP_EN`.
- Defined:
  - `sweep_start` sampled in IDLE takes precedence over external requests in the same cycle; no `req_ready` is issued that cycle.
  - The sweep drives vectors 0..2^IN_W-1 in ascending order, each through DRIVE/RESP with `rsp_id` = NREQ.
  - `rsp_last` = 1 on vector 2^IN_W-1.
  - `sweep_busy` is high from the cycle after start until that last handshake. External requests are blocked throughout, and `rr_ptr` is unchanged.
  - `sweep_start` outside IDLE is ignored.
- Undefined: `sweep_start` is ignored; `sweep_busy` and `rsp_last` are tied 0. Ports remain.

## Structure
- Package `ccg_sched_pkg`: state enum (IDLE/DRIVE/RESP), default width constants `CCG_IN_W`=4 and `CCG_OUT_W`=9, and the sweep id function (returns NREQ).
- Sub-module `ccg_rr_arbiter`: parameterised NREQ. Inputs `req`, `ptr`; outputs one-hot `gnt` and encoded `idx`. Purely combinational.
- The pointer update and FSM live in `ccg_eval_sched`.

## Test plan
- Single request: NREQ=4, SETTLE=1, requester 2 sends x=4'b0101, circuit model f = {~x0&~x3, …} → `req_ready`=4'b0100 at T; `rsp_valid` at T+2, `rsp_id`=2, `rsp_x`=5, `rsp_f` = model(5).
- Round robin: all four requesters valid continuously, `rsp_ready`=1 → grant order 0,1,2,3,0; each response id matches; no requester is granted twice before the others.
- Backpressure: `rsp_ready`=0 for 5 cycles in RESP → `rsp_*` held stable, `req_ready`=0 throughout; a single handshake on release, then IDLE.
- Settle: SETTLE=3, `eval_f` model delayed 2 cycles → `rsp_f` equals the settled value; `eval_x` is held 3 cycles.
- Sweep (`CCG_SWEEP_EN`): pulse `sweep_start` with requester 1 also valid → 16 responses, `rsp_x` 0..15, `rsp_id`=4, `rsp_last` only on x=15. Requester 1 is granted in the IDLE cycle after `sweep_busy` falls.
- Async reset: assert `rst_n`=0 mid-DRIVE → all outputs 0 immediately. After release, no stale response appears, and the first grant goes to requester 0.
